// File: rtl/stream_demux_1to2_if.sv
// Bundle of the shared input stream, the two routed output streams and the packet counters.
// The slave modport is the demux side; the master modport is the source/consumer side.
interface stream_demux_1to2_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_sel;

    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] a_data;
    logic              a_last;

    logic              b_valid;
    logic              b_ready;
    logic [DATA_W-1:0] b_data;
    logic              b_last;

    logic [CNT_W-1:0]  a_pkt_cnt;
    logic [CNT_W-1:0]  b_pkt_cnt;

    modport master (
        output in_valid, in_data, in_last, in_sel, a_ready, b_ready,
        input  in_ready, a_valid, a_data, a_last, b_valid, b_data, b_last,
               a_pkt_cnt, b_pkt_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, in_sel, a_ready, b_ready,
        output in_ready, a_valid, a_data, a_last, b_valid, b_data, b_last,
               a_pkt_cnt, b_pkt_cnt
    );
endinterface

// File: rtl/stream_demux_1to2.sv
// Packet-aware 1:2 stream demux: the route is chosen on a packet's first beat and held
// until its last beat; each output sits behind a one-entry register slice.
module stream_demux_1to2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    stream_demux_1to2_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

    state_t            state_q, state_d;
    logic              route_b;
    logic              in_ready;
    logic              accept;

    // Index 0 is port A, index 1 is port B.
    logic [1:0]        slice_ready;
    logic [1:0]        slice_valid;
    logic [1:0]        slice_drain;
    logic [1:0]        slice_load;
    logic [1:0]        slice_last;
    logic [DATA_W-1:0] slice_data [2];
    logic [CNT_W-1:0]  slice_cnt  [2];

    assign slice_ready = {bus.b_ready, bus.a_ready};
    assign accept      = bus.in_valid & in_ready;
    assign slice_load  = {accept & route_b, accept & ~route_b};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !bus.in_last) begin
                    state_d = bus.in_sel ? LOCK_B : LOCK_A;
                end
            end
            LOCK_A, LOCK_B: begin
                if (accept && bus.in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: a slice that drains this cycle can take the next beat in the same cycle.
    always_comb begin
        route_b  = (state_q == LOCK_B) || ((state_q == IDLE) && bus.in_sel);
        in_ready = rst_n && (route_b ? (!slice_valid[1] || slice_drain[1])
                                     : (!slice_valid[0] || slice_drain[0]));
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slice
            logic              valid_q;
            logic              last_q;
            logic [DATA_W-1:0] data_q;
            logic [CNT_W-1:0]  cnt_q;

            assign slice_drain[gi] = valid_q & slice_ready[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    data_q  <= '0;
                end else if (slice_load[gi]) begin
                    valid_q <= 1'b1;
                    last_q  <= bus.in_last;
                    data_q  <= bus.in_data;
                end else if (slice_drain[gi]) begin
                    valid_q <= 1'b0;
                end
            end

            // Saturating count of completed packets handed to the consumer.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (slice_drain[gi] && last_q && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            assign slice_valid[gi] = valid_q;
            assign slice_last[gi]  = last_q;
            assign slice_data[gi]  = data_q;
            assign slice_cnt[gi]   = cnt_q;
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.a_valid   = slice_valid[0];
    assign bus.a_data    = slice_data[0];
    assign bus.a_last    = slice_last[0];
    assign bus.b_valid   = slice_valid[1];
    assign bus.b_data    = slice_data[1];
    assign bus.b_last    = slice_last[1];
    assign bus.a_pkt_cnt = slice_cnt[0];
    assign bus.b_pkt_cnt = slice_cnt[1];
endmodule
